// File: rtl/monster_wave_controller.sv
// Invader fleet sequencer: alive tracking, march speed, round-robin enemy shots and wave flow.
// All outputs registered; fireReq holds with fireIndex until fireAck, dropping the cycle after.
module monster_wave_controller #(
    parameter int NUM_MONSTERS = 16,
    parameter int SHOT_PERIOD  = 45,
    parameter int CLEAR_PAUSE  = 60,
    parameter int BASE_SPEED   = 30,
    parameter int SPEED_STEP   = 2,
    parameter int MAX_WAVE     = 15
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    gameStart,
    input  logic                    hitValid,
    input  logic [4:0]              hitIndex,
    input  logic                    fleetAtBottom,
    input  logic                    fireAck,
    output logic [NUM_MONSTERS-1:0] aliveMask,
    output logic [7:0]              marchSpeed,
    output logic                    fireReq,
    output logic [4:0]              fireIndex,
    output logic [3:0]              waveNum,
    output logic                    respawnPulse,
    output logic                    playing,
    output logic                    gameOver
);

    typedef enum logic [2:0] {IDLE, SPAWN, PLAY, CLEAR, GAME_OVER} state_t;

    state_t       state;
    logic [5:0]   kill_count;
    logic [4:0]   rr_ptr;
    logic [15:0]  shot_cnt;
    logic [15:0]  pause_cnt;

    logic [NUM_MONSTERS-1:0] hit_onehot;
    logic [NUM_MONSTERS-1:0] alive_after_hit;
    logic [NUM_MONSTERS-1:0] rot_alive;
    logic [5:0]              rot_amt;
    logic                    hit_ok;
    logic                    sel_found;
    logic [4:0]              sel_idx;
    int                      sel_off;
    int                      sel_tmp;
    logic                    shot_due;
    logic                    pause_done;
    logic [15:0]             speed_sum;

    always_comb begin
        hit_onehot      = {{(NUM_MONSTERS-1){1'b0}}, 1'b1} << hitIndex;
        alive_after_hit = aliveMask & ~hit_onehot;
        hit_ok          = hitValid && ({27'd0, hitIndex} < 32'(NUM_MONSTERS)) &&
                          ((aliveMask & hit_onehot) != '0);

        // Rotate so bit 0 is monster rrPtr+1; the lowest set bit is the next shooter.
        rot_amt   = {1'b0, rr_ptr} + 6'd1;
        rot_alive = NUM_MONSTERS'({aliveMask, aliveMask} >> rot_amt);
        sel_found = 1'b0;
        sel_off   = 0;
        for (int k = NUM_MONSTERS - 1; k >= 0; k--) begin
            if (rot_alive[k]) begin
                sel_found = 1'b1;
                sel_off   = k;
            end
        end
        sel_tmp = int'(rr_ptr) + 1 + sel_off;
        if (sel_tmp >= NUM_MONSTERS) begin
            sel_tmp = sel_tmp - NUM_MONSTERS;
        end
        sel_idx = 5'(sel_tmp);

        shot_due   = startOfFrame && (shot_cnt == 16'(SHOT_PERIOD - 1));
        pause_done = startOfFrame && (pause_cnt == 16'(CLEAR_PAUSE - 1));
        speed_sum  = 16'(BASE_SPEED) + 16'(SPEED_STEP) * (16'(kill_count) + 16'(waveNum));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            aliveMask    <= '0;
            kill_count   <= '0;
            waveNum      <= '0;
            marchSpeed   <= 8'(BASE_SPEED);
            fireReq      <= 1'b0;
            fireIndex    <= '0;
            rr_ptr       <= 5'(NUM_MONSTERS - 1);
            shot_cnt     <= '0;
            pause_cnt    <= '0;
            respawnPulse <= 1'b0;
            playing      <= 1'b0;
            gameOver     <= 1'b0;
        end else begin
            respawnPulse <= 1'b0;
            marchSpeed   <= (speed_sum > 16'd255) ? 8'd255 : speed_sum[7:0];
            if (fireReq && fireAck) begin
                fireReq <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (gameStart) begin
                        state        <= SPAWN;
                        respawnPulse <= 1'b1;
                    end
                end

                SPAWN: begin
                    aliveMask  <= '1;
                    kill_count <= '0;
                    shot_cnt   <= '0;
                    state      <= PLAY;
                    playing    <= 1'b1;
                end

                PLAY: begin
                    if (fleetAtBottom) begin
                        state    <= GAME_OVER;
                        playing  <= 1'b0;
                        gameOver <= 1'b1;
                        fireReq  <= 1'b0;
                    end else begin
                        if (startOfFrame) begin
                            shot_cnt <= shot_due ? 16'd0 : shot_cnt + 16'd1;
                        end
                        // Selection sees the pre-hit mask, so a same-cycle hit cannot redirect it.
                        if (shot_due && !fireReq && sel_found) begin
                            fireReq   <= 1'b1;
                            fireIndex <= sel_idx;
                            rr_ptr    <= sel_idx;
                        end
                        if (hit_ok) begin
                            aliveMask  <= alive_after_hit;
                            kill_count <= kill_count + 6'd1;
                            if (alive_after_hit == '0) begin
                                state     <= CLEAR;
                                playing   <= 1'b0;
                                pause_cnt <= '0;
                                fireReq   <= 1'b0;
                            end
                        end
                    end
                end

                CLEAR: begin
                    fireReq <= 1'b0;
                    if (startOfFrame) begin
                        if (pause_done) begin
                            waveNum      <= (waveNum >= 4'(MAX_WAVE)) ? 4'(MAX_WAVE) : waveNum + 4'd1;
                            state        <= SPAWN;
                            respawnPulse <= 1'b1;
                        end else begin
                            pause_cnt <= pause_cnt + 16'd1;
                        end
                    end
                end

                GAME_OVER: begin
                    fireReq <= 1'b0;
                    if (gameStart) begin
                        waveNum      <= '0;
                        state        <= SPAWN;
                        respawnPulse <= 1'b1;
                        gameOver     <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    playing  <= 1'b0;
                    gameOver <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_monster_wave_controller.sv
// Directed bench for monster_wave_controller: hit table plus shot, wave and reset sequences.
module tb_monster_wave_controller;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        gameStart;
    logic        hitValid;
    logic [4:0]  hitIndex;
    logic        fleetAtBottom;
    logic        fireAck;
    logic [15:0] aliveMask;
    logic [7:0]  marchSpeed;
    logic        fireReq;
    logic [4:0]  fireIndex;
    logic [3:0]  waveNum;
    logic        respawnPulse;
    logic        playing;
    logic        gameOver;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  idx;
        logic        vld;
        logic [15:0] exp_alive;
        logic [7:0]  exp_speed;
    } hit_vec_t;

    hit_vec_t hv[5];

    monster_wave_controller dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .gameStart    (gameStart),
        .hitValid     (hitValid),
        .hitIndex     (hitIndex),
        .fleetAtBottom(fleetAtBottom),
        .fireAck      (fireAck),
        .aliveMask    (aliveMask),
        .marchSpeed   (marchSpeed),
        .fireReq      (fireReq),
        .fireIndex    (fireIndex),
        .waveNum      (waveNum),
        .respawnPulse (respawnPulse),
        .playing      (playing),
        .gameOver     (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic hit(input int idx);
        hitIndex = 5'(idx);
        hitValid = 1'b1;
        tick();
        hitValid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " aliveMask"},    32'(aliveMask),    32'h0);
        check({tag, " marchSpeed"},   32'(marchSpeed),   32'd30);
        check({tag, " fireReq"},      32'(fireReq),      32'd0);
        check({tag, " fireIndex"},    32'(fireIndex),    32'd0);
        check({tag, " waveNum"},      32'(waveNum),      32'd0);
        check({tag, " respawnPulse"}, 32'(respawnPulse), 32'd0);
        check({tag, " playing"},      32'(playing),      32'd0);
        check({tag, " gameOver"},     32'(gameOver),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs_cnt;

        hv[0] = '{idx: 5'd3,  vld: 1'b1, exp_alive: 16'hFFF7, exp_speed: 8'd32};
        hv[1] = '{idx: 5'd3,  vld: 1'b1, exp_alive: 16'hFFF7, exp_speed: 8'd32};
        hv[2] = '{idx: 5'd20, vld: 1'b1, exp_alive: 16'hFFF7, exp_speed: 8'd32};
        hv[3] = '{idx: 5'd0,  vld: 1'b1, exp_alive: 16'hFFF6, exp_speed: 8'd34};
        hv[4] = '{idx: 5'd5,  vld: 1'b0, exp_alive: 16'hFFF6, exp_speed: 8'd34};

        resetN = 1'b0;
        startOfFrame = 1'b0;
        gameStart = 1'b0;
        hitValid = 1'b0;
        hitIndex = '0;
        fleetAtBottom = 1'b0;
        fireAck = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        resetN = 1'b1;
        tick();

        // Start: exactly one respawn pulse, full fleet at base speed
        gameStart = 1'b1;
        tick();
        gameStart = 1'b0;
        rs_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (respawnPulse) rs_cnt++;
            tick();
        end
        check("respawn pulse width", 32'(rs_cnt), 32'd1);
        check("start aliveMask", 32'(aliveMask), 32'hFFFF);
        check("start marchSpeed", 32'(marchSpeed), 32'd30);
        check("start playing", 32'(playing), 32'd1);

        for (int i = 0; i < 5; i++) begin
            hitIndex = hv[i].idx;
            hitValid = hv[i].vld;
            tick();
            hitValid = 1'b0;
            tick();
            tick();
            check($sformatf("hit vec %0d aliveMask", i), 32'(aliveMask), 32'(hv[i].exp_alive));
            check($sformatf("hit vec %0d marchSpeed", i), 32'(marchSpeed), 32'(hv[i].exp_speed));
        end

        // Shot scheduling: monster 0 dead so first shot comes from 1
        repeat (44) frame();
        check("no shot before period", 32'(fireReq), 32'd0);
        frame();
        check("shot1 req/index", {26'd0, fireReq, fireIndex}, {26'd0, 1'b1, 5'd1});
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("shot1 hold cycle %0d", i), {26'd0, fireReq, fireIndex}, {26'd0, 1'b1, 5'd1});
        end
        fireAck = 1'b1;
        tick();
        fireAck = 1'b0;
        check("fireReq drops after ack", 32'(fireReq), 32'd0);
        repeat (45) frame();
        check("shot2 req/index", {26'd0, fireReq, fireIndex}, {26'd0, 1'b1, 5'd2});

        // Killing the pending shooter leaves the request intact
        hit(2);
        tick();
        check("pending shot after kill", {26'd0, fireReq, fireIndex}, {26'd0, 1'b1, 5'd2});
        check("aliveMask after kill 2", 32'(aliveMask), 32'hFFF2);

        // Clear the wave
        for (int i = 0; i < 16; i++) hit(i);
        tick();
        tick();
        check("cleared aliveMask", 32'(aliveMask), 32'h0);
        check("cleared playing", 32'(playing), 32'd0);
        check("clear abandons shot", 32'(fireReq), 32'd0);
        check("speed at 16 kills", 32'(marchSpeed), 32'd62);
        repeat (59) frame();
        check("still paused after 59 frames", {31'd0, respawnPulse}, 32'd0);
        check("aliveMask during pause", 32'(aliveMask), 32'h0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("respawn after pause", 32'(respawnPulse), 32'd1);
        check("waveNum after clear", 32'(waveNum), 32'd1);
        tick();
        check("wave1 aliveMask", 32'(aliveMask), 32'hFFFF);
        check("wave1 playing", 32'(playing), 32'd1);
        tick();
        check("wave1 marchSpeed", 32'(marchSpeed), 32'd32);

        // Game over with a pending shot and a same-cycle last hit
        repeat (45) frame();
        check("wave1 shot req/index", {26'd0, fireReq, fireIndex}, {26'd0, 1'b1, 5'd3});
        for (int i = 0; i < 15; i++) hit(i);
        tick();
        check("one monster left", 32'(aliveMask), 32'h8000);
        hitIndex = 5'd15;
        hitValid = 1'b1;
        fleetAtBottom = 1'b1;
        tick();
        hitValid = 1'b0;
        fleetAtBottom = 1'b0;
        check("gameOver asserted", 32'(gameOver), 32'd1);
        check("gameOver playing low", 32'(playing), 32'd0);
        check("gameOver fireReq low", 32'(fireReq), 32'd0);
        tick();
        check("gameOver holds", 32'(gameOver), 32'd1);
        gameStart = 1'b1;
        tick();
        gameStart = 1'b0;
        check("restart waveNum", 32'(waveNum), 32'd0);
        check("restart respawn", 32'(respawnPulse), 32'd1);
        check("restart gameOver", 32'(gameOver), 32'd0);
        tick();
        check("restart aliveMask", 32'(aliveMask), 32'hFFFF);
        check("restart playing", 32'(playing), 32'd1);
        tick();
        check("restart marchSpeed", 32'(marchSpeed), 32'd30);

        // Asynchronous reset in the middle of a pending handshake
        hit(7);
        tick();
        tick();
        check("speed before reset", 32'(marchSpeed), 32'd32);
        repeat (45) frame();
        check("pre-reset shot", {26'd0, fireReq, fireIndex}, {26'd0, 1'b1, 5'd4});
        #3;
        resetN = 1'b0;
        #1;
        check_reset_outputs("async reset");
        tick();
        resetN = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
